alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one 32-bit `Alu` instance between two requesters: port 0 (core execute stage) and port 1 (auxiliary unit, e.g. CSR/debug address generation). Each port has a valid/ready request channel and a one-entry registered response slot with valid/ready backpressure. Arbitration is round-robin or fixed-priority. An optional lock lets one port hold the ALU across a multi-operation sequence.

## Interface
Parameters:
- `FIXED_PRIORITY`, default 0: 0 = round-robin; 1 = port 0 always wins when both ports are eligible.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when `valid & ready`.
- `req0_op` / `req1_op`  in  4  ALU operation code.
- `req0_x`, `req0_y` / `req1_x`, `req1_y`  in  32  operands.
- `req0_lock` / `req1_lock`  in  1  keep the grant after this op.
- `rsp0_valid` / `rsp1_valid`  out  1  result held in the response slot.
- `rsp0_ready` / `rsp1_ready`  in  1  consumer takes the result.
- `rsp0_result` / `rsp1_result`  out  32  registered ALU output.
- `rsp0_zero` / `rsp1_zero`  out  1  registered ALU zero flag.
- `busy`  out  1  state is not ARB, or any `rspN_valid` is 1.

## Operation
- Slot free(N) = `!rspN_valid | rspN_ready`. Eligible(N) = `reqN_valid & slot free(N)`.
- FSM states:
  - ARB: grant the single eligible port.
    - Both eligible and `FIXED_PRIORITY=0`: grant the port that is not `last_grant`.
    - Both eligible and `FIXED_PRIORITY=1`: grant port 0.
  - LOCK0 / LOCK1: only port 0 / port 1 can be granted. The other port's ready is held at 0 even when the ALU is idle.
- `reqN_ready` is combinational: it equals grant(N). It may depend on `reqN_valid`. At most one ready is high per cycle.
- The ALU mux drives the granted port's op, x and y. With no grant it drives port 0's inputs, and the result is discarded.
- On acceptance from port N:
  - The next edge loads `rspN_result`/`rspN_zero` from the ALU and sets `rspN_valid`=1.
  - `last_grant` is set to N.
  - Next state is LOCKN if `reqN_lock`=1, else ARB.
- Lock release: in LOCKN, an accepted request with `lock`=0 returns the FSM to ARB. LOCKN with no acceptance holds indefinitely.
- The response slot holds a stable value while `rspN_valid & !rspN_ready`.
- Same-cycle drain and refill: `rspN_ready`=1 together with a new acceptance on port N overwrites the slot. `rspN_valid` stays 1.
- Drain only: `rspN_ready`=1 with no acceptance clears `rspN_valid` at the next edge.
- The ALU result width is 32 bits. Op codes pass through unmodified. Undefined codes return X, per the ALU default.

## Timing
- Latency: 1 cycle, from the acceptance edge to `rspN_valid`=1.
- Throughput: 1 op/cycle in aggregate. A single port sustains 1 op/cycle only while its consumer keeps `rspN_ready`=1.
- Reset values (while `reset`=0 at an edge):
  - FSM = ARB, `last_grant` = 1 (so port 0 wins the first tie).
  - `rsp*_valid`, `rsp*_result`, `rsp*_zero`, `busy` = 0.
  - `req*_ready` is forced to 0 combinationally while `reset`=0.
- Reset mid-operation, including during a lock: pending responses are dropped and the lock is released. No response appears afterwards.
- Round-robin tie-break uses only `last_grant`. Cycles where only one port is eligible still update `last_grant`.

## Structure
- Shared package/include `alu_defs`:
  - the 4-bit ALU op codes: AND 0000, OR 0001, SUM 0010, SUB 0110, SLT 0111, SHIFT_RIGHT_A 0011, SHIFT_LEFT 1000, SHIFT_RIGHT 1001, XOR 1010, GREATER_EQUAL 1011, NOR 1100, GREATER_EQUAL_U 1101, EQUAL 1110, SLT_U 1111;
  - arbiter state encodings ARB=2'd0, LOCK0=2'd1, LOCK1=2'd2.
- One sub-module: the existing core `Alu`, instantiated once. Grant mux, FSM and response registers live in `alu_arbiter`.

## Test plan
- Port 0 only, SUM x=5 y=7 → `req0_ready`=1 the same cycle; next cycle `rsp0_valid`=1, `rsp0_result`=12, `rsp0_zero`=0.
- Both ports valid every cycle, `FIXED_PRIORITY=0`, port 0 SUB 9-9 and port 1 XOR 0xF0^0x0F, responses always ready → grants alternate 0,1,0,1…; `rsp0_result`=0 with `zero`=1; `rsp1_result`=0xFF with `zero`=0.
- `rsp1_ready`=0 with `rsp1_valid`=1 and `req1_valid`=1 → `req1_ready`=0 and the slot is held stable; port 0 keeps being served; raising `rsp1_ready` lets port 1 be granted in that same cycle.
- Port 1 issues SLT_U with `lock`=1, then idles 3 cycles, then SUM with `lock`=0, while port 0 is valid throughout → `req0_ready`=0 for all of those cycles; port 0 is granted the cycle after the unlocking SUM.
- `FIXED_PRIORITY=1`, both ports valid for 4 cycles → port 0 granted in all 4 cycles; port 1 never granted.
- Reset asserted while in LOCK0 with `rsp0_valid`=1 → next cycle state ARB, `rsp0_valid`=0, `busy`=0; then a tie grants port 0 first.

Source files
------------

// File: rtl/alu_defs.sv
// Shared ALU op codes and arbiter state encodings for the shared-ALU arbiter slice.
package alu_defs;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_SUM   = 4'b0010;
  localparam logic [3:0] ALU_SRA   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_XOR   = 4'b1010;
  localparam logic [3:0] ALU_GE    = 4'b1011;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_GEU   = 4'b1101;
  localparam logic [3:0] ALU_EQ    = 4'b1110;
  localparam logic [3:0] ALU_SLTU  = 4'b1111;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/Alu.sv
// Core 32-bit combinational ALU; undefined op codes yield X so misuse is visible in simulation.
module Alu
  import alu_defs::*;
(
  input  logic [3:0]  alu_control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  // Operation decode and zero flag.
  always_comb begin
    result = {32{1'bx}};
    case (alu_control)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_SUM:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_XOR:  result = a ^ b;
      ALU_GE:   result = {31'd0, $signed(a) >= $signed(b)};
      ALU_NOR:  result = ~(a | b);
      ALU_GEU:  result = {31'd0, a >= b};
      ALU_EQ:   result = {31'd0, a == b};
      ALU_SLTU: result = {31'd0, a < b};
      default:  result = {32{1'bx}};
    endcase
    zero = (result == 32'd0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one Alu: round-robin or fixed priority, optional per-port lock,
// and a one-entry registered response slot per port.
module alu_arbiter
  import alu_defs::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic        req0_lock,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  input  logic        req1_lock,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic        busy
);

  arb_state_e  state_r, state_next_s;
  logic        last_grant_r;
  logic        elig0_s, elig1_s, grant0_s, grant1_s;
  logic        rsp0_vnext_s, rsp1_vnext_s;
  logic [3:0]  alu_op_s;
  logic [31:0] alu_x_s, alu_y_s, alu_result_s;
  logic        alu_zero_s;

  assign elig0_s = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1_s = req1_valid & (~rsp1_valid | rsp1_ready);

  // Grant selection and next-state; grants are forced low while reset is asserted.
  always_comb begin
    grant0_s     = 1'b0;
    grant1_s     = 1'b0;
    state_next_s = ARB;
    if (!reset) begin
      state_next_s = ARB;
    end else begin
      case (state_r)
        ARB: begin
          if (elig0_s && elig1_s) begin
            if ((FIXED_PRIORITY != 0) || last_grant_r) begin
              grant0_s = 1'b1;
            end else begin
              grant1_s = 1'b1;
            end
          end else if (elig0_s) begin
            grant0_s = 1'b1;
          end else if (elig1_s) begin
            grant1_s = 1'b1;
          end else begin
            grant0_s = 1'b0;
          end
        end
        LOCK0:   grant0_s = elig0_s;
        LOCK1:   grant1_s = elig1_s;
        default: grant0_s = 1'b0;
      endcase
      // A lock holds only while no unlocking op is accepted; illegal states fall back to ARB.
      if (grant0_s) begin
        state_next_s = req0_lock ? LOCK0 : ARB;
      end else if (grant1_s) begin
        state_next_s = req1_lock ? LOCK1 : ARB;
      end else begin
        state_next_s = ((state_r == LOCK0) || (state_r == LOCK1)) ? state_r : ARB;
      end
    end
  end

  assign req0_ready   = grant0_s;
  assign req1_ready   = grant1_s;
  assign rsp0_vnext_s = grant0_s | (rsp0_valid & ~rsp0_ready);
  assign rsp1_vnext_s = grant1_s | (rsp1_valid & ~rsp1_ready);

  assign alu_op_s = grant1_s ? req1_op : req0_op;
  assign alu_x_s  = grant1_s ? req1_x  : req0_x;
  assign alu_y_s  = grant1_s ? req1_y  : req0_y;

  Alu u_alu (
    .alu_control (alu_op_s),
    .a           (alu_x_s),
    .b           (alu_y_s),
    .result      (alu_result_s),
    .zero        (alu_zero_s)
  );

  // State, tie-break history and response slots.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ARB;
      last_grant_r <= 1'b1;
      rsp0_valid   <= 1'b0;
      rsp0_result  <= 32'd0;
      rsp0_zero    <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_result  <= 32'd0;
      rsp1_zero    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      rsp0_valid <= rsp0_vnext_s;
      rsp1_valid <= rsp1_vnext_s;
      busy       <= (state_next_s != ARB) | rsp0_vnext_s | rsp1_vnext_s;
      if (grant0_s) begin
        last_grant_r <= 1'b0;
        rsp0_result  <= alu_result_s;
        rsp0_zero    <= alu_zero_s;
      end else if (grant1_s) begin
        last_grant_r <= 1'b1;
        rsp1_result  <= alu_result_s;
        rsp1_zero    <= alu_zero_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus and are
// compared against a transaction-level model of slots, owner lock and last winner.
module tb_alu_arbiter;
  import alu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  v, lk, rrdy;
  logic [3:0]  op [2];
  logic [31:0] x [2];
  logic [31:0] y [2];
  logic [1:0]  rdy_a, rdy_b, rv_a, rv_b, z_a, z_b;
  logic [31:0] res_a0, res_a1, res_b0, res_b1;
  logic        busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  bit          m_rv    [2][2];
  logic [31:0] m_res   [2][2];
  int          m_owner [2];
  int          m_last  [2];
  int          eg      [2];
  logic [3:0]  op_tab  [14];

  always #5 clk = ~clk;

  alu_arbiter #(.FIXED_PRIORITY(0)) dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req0_ready(rdy_a[0]), .req0_op(op[0]), .req0_x(x[0]), .req0_y(y[0]), .req0_lock(lk[0]),
    .req1_valid(v[1]), .req1_ready(rdy_a[1]), .req1_op(op[1]), .req1_x(x[1]), .req1_y(y[1]), .req1_lock(lk[1]),
    .rsp0_valid(rv_a[0]), .rsp0_ready(rrdy[0]), .rsp0_result(res_a0), .rsp0_zero(z_a[0]),
    .rsp1_valid(rv_a[1]), .rsp1_ready(rrdy[1]), .rsp1_result(res_a1), .rsp1_zero(z_a[1]),
    .busy(busy_a));

  alu_arbiter #(.FIXED_PRIORITY(1)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req0_ready(rdy_b[0]), .req0_op(op[0]), .req0_x(x[0]), .req0_y(y[0]), .req0_lock(lk[0]),
    .req1_valid(v[1]), .req1_ready(rdy_b[1]), .req1_op(op[1]), .req1_x(x[1]), .req1_y(y[1]), .req1_lock(lk[1]),
    .rsp0_valid(rv_b[0]), .rsp0_ready(rrdy[0]), .rsp0_result(res_b0), .rsp0_zero(z_b[0]),
    .rsp1_valid(rv_b[1]), .rsp1_ready(rrdy[1]), .rsp1_result(res_b1), .rsp1_zero(z_b[1]),
    .busy(busy_b));

  function automatic logic [31:0] ref_alu(logic [3:0] o, logic [31:0] a, logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (o)
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_SUM:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SRA:  return (a >> sh) | ((a[31] && sh != 5'd0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_XOR:  return a ^ b;
      ALU_GE:   return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      ALU_NOR:  return ~(a | b);
      ALU_GEU:  return (a >= b) ? 32'd1 : 32'd0;
      ALU_EQ:   return (a == b) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] get_rdy(int i);  return (i == 0) ? rdy_a : rdy_b;   endfunction
  function automatic logic [1:0] get_rv(int i);   return (i == 0) ? rv_a : rv_b;     endfunction
  function automatic logic [1:0] get_z(int i);    return (i == 0) ? z_a : z_b;       endfunction
  function automatic logic       get_busy(int i); return (i == 0) ? busy_a : busy_b; endfunction
  function automatic logic [31:0] get_res(int i, int p);
    if (i == 0) return (p == 0) ? res_a0 : res_a1;
    return (p == 0) ? res_b0 : res_b1;
  endfunction
  function automatic logic [1:0] exp_rdy(int i);
    return (eg[i] == 0) ? 2'b01 : (eg[i] == 1) ? 2'b10 : 2'b00;
  endfunction

  task automatic drive(int p, logic vv, logic [3:0] o, logic [31:0] a, logic [31:0] b, logic l);
    v[p] = vv; op[p] = o; x[p] = a; y[p] = b; lk[p] = l;
  endtask

  // Let combinational outputs settle, then decide who the model says wins this cycle.
  task automatic eval_grants();
    bit e [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      eg[i] = -1;
      for (int p = 0; p < 2; p++) e[p] = v[p] && (!m_rv[i][p] || rrdy[p]);
      if (reset) begin
        if (m_owner[i] >= 0)   eg[i] = e[m_owner[i]] ? m_owner[i] : -1;
        else if (e[0] && e[1]) eg[i] = (i == 1) ? 0 : 1 - m_last[i];
        else if (e[0])         eg[i] = 0;
        else if (e[1])         eg[i] = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_owner[i] = -1; m_last[i] = 1;
        for (int p = 0; p < 2; p++) begin m_rv[i][p] = 1'b0; m_res[i][p] = 32'd0; end
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (eg[i] == p) begin
            m_rv[i][p]  = 1'b1;
            m_res[i][p] = ref_alu(op[p], x[p], y[p]);
            m_last[i]   = p;
            m_owner[i]  = lk[p] ? p : -1;
          end else if (rrdy[p]) begin
            m_rv[i][p] = 1'b0;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; rrdy = 2'b00;
    drive(0, 1'b1, ALU_SUM, 32'd1, 32'd2, 1'b0);
    drive(1, 1'b1, ALU_SUM, 32'd3, 32'd4, 1'b0);
    eval_grants();
    total++; if (rdy_a !== 2'b00 || rdy_b !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b/%b exp=00/00", rdy_a, rdy_b); end
    tick(); eval_grants(); tick();
    v = 2'b00; eval_grants();
    total++; if (rv_a !== 2'b00 || rv_b !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b/%b exp=00/00", rv_a, rv_b); end
    total++; if (res_a0 !== 32'd0 || res_a1 !== 32'd0 || z_a !== 2'b00) begin bad++; $display("FAIL reset_rsp_data got=%h/%h/%b exp=0/0/00", res_a0, res_a1, z_a); end
    total++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b/%b exp=0/0", busy_a, busy_b); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    rrdy = 2'b11;
    drive(0, 1'b1, ALU_SUM, 32'd5, 32'd7, 1'b0); v[1] = 1'b0;
    eval_grants();
    total++; if (rdy_a !== 2'b01 || rdy_b !== 2'b01) begin bad++; $display("FAIL single_ready got=%b/%b exp=01/01", rdy_a, rdy_b); end
    tick();
    v = 2'b00; eval_grants();
    total++; if (rv_a[0] !== 1'b1 || res_a0 !== 32'd12 || z_a[0] !== 1'b0) begin bad++; $display("FAIL single_rsp got=%b/%0d/%b exp=1/12/0", rv_a[0], res_a0, z_a[0]); end
    tick(); eval_grants();
    total++; if (rv_a !== 2'b00 || busy_a !== 1'b0) begin bad++; $display("FAIL single_drain got=%b/%b exp=00/0", rv_a, busy_a); end
    tick();
  endtask

  task automatic test_alternate();
    logic [1:0] prev;
    rrdy = 2'b11; prev = 2'b00;
    drive(0, 1'b1, ALU_SUB, 32'd9, 32'd9, 1'b0);
    drive(1, 1'b1, ALU_XOR, 32'h0000_00F0, 32'h0000_000F, 1'b0);
    for (int c = 0; c < 6; c++) begin
      eval_grants();
      total++; if (rdy_a !== exp_rdy(0) || rdy_a === prev || rdy_a === 2'b00) begin bad++; $display("FAIL alt_rr_grant cyc=%0d got=%b exp=%b", c, rdy_a, exp_rdy(0)); end
      total++; if (rdy_b !== 2'b01) begin bad++; $display("FAIL alt_fixed_grant cyc=%0d got=%b exp=01", c, rdy_b); end
      if (c > 1) begin
        total++; if (res_a0 !== 32'd0 || z_a[0] !== 1'b1) begin bad++; $display("FAIL alt_sub got=%h/%b exp=0/1", res_a0, z_a[0]); end
        total++; if (res_a1 !== 32'h0000_00FF || z_a[1] !== 1'b0) begin bad++; $display("FAIL alt_xor got=%h/%b exp=ff/0", res_a1, z_a[1]); end
      end
      prev = rdy_a;
      tick();
    end
    v = 2'b00; eval_grants(); tick();
  endtask

  task automatic test_backpressure();
    rrdy = 2'b01;
    drive(1, 1'b1, ALU_SUM, 32'd3, 32'd4, 1'b0); v[0] = 1'b0;
    eval_grants();
    total++; if (rdy_a !== 2'b10) begin bad++; $display("FAIL bp_first got=%b exp=10", rdy_a); end
    tick();
    drive(0, 1'b1, ALU_SUM, 32'd1, 32'd1, 1'b0);
    drive(1, 1'b1, ALU_SUM, 32'd100, 32'd100, 1'b0);
    for (int c = 0; c < 3; c++) begin
      eval_grants();
      total++; if (rdy_a !== 2'b01) begin bad++; $display("FAIL bp_hold_ready cyc=%0d got=%b exp=01", c, rdy_a); end
      total++; if (rv_a[1] !== 1'b1 || res_a1 !== 32'd7) begin bad++; $display("FAIL bp_hold_slot cyc=%0d got=%b/%0d exp=1/7", c, rv_a[1], res_a1); end
      tick();
    end
    rrdy = 2'b11; eval_grants();
    total++; if (rdy_a !== 2'b10) begin bad++; $display("FAIL bp_release got=%b exp=10", rdy_a); end
    tick();
    v = 2'b00; eval_grants();
    total++; if (rv_a[1] !== 1'b1 || res_a1 !== 32'd200) begin bad++; $display("FAIL bp_refill got=%b/%0d exp=1/200", rv_a[1], res_a1); end
    tick();
  endtask

  task automatic test_lock();
    rrdy = 2'b11;
    drive(0, 1'b1, ALU_SUM, 32'd8, 32'd8, 1'b0); v[1] = 1'b0;
    eval_grants(); tick();
    drive(1, 1'b1, ALU_SLTU, 32'd1, 32'd2, 1'b1);
    eval_grants();
    total++; if (rdy_a !== 2'b10) begin bad++; $display("FAIL lock_take got=%b exp=10", rdy_a); end
    tick();
    v[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      eval_grants();
      total++; if (rdy_a !== 2'b00 || busy_a !== 1'b1) begin bad++; $display("FAIL lock_hold cyc=%0d got=%b/%b exp=00/1", c, rdy_a, busy_a); end
      if (c == 0) begin
        total++; if (res_a1 !== 32'd1 || rv_a[1] !== 1'b1) begin bad++; $display("FAIL lock_sltu got=%0d/%b exp=1/1", res_a1, rv_a[1]); end
      end
      tick();
    end
    drive(1, 1'b1, ALU_SUM, 32'd2, 32'd3, 1'b0);
    eval_grants();
    total++; if (rdy_a !== 2'b10) begin bad++; $display("FAIL lock_release got=%b exp=10", rdy_a); end
    tick();
    eval_grants();
    total++; if (rdy_a !== 2'b01) begin bad++; $display("FAIL lock_after got=%b exp=01", rdy_a); end
    tick();
    v = 2'b00; eval_grants(); tick();
  endtask

  task automatic test_reset_in_lock();
    rrdy = 2'b00;
    drive(0, 1'b1, ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1); v[1] = 1'b0;
    eval_grants();
    total++; if (rdy_a !== 2'b01) begin bad++; $display("FAIL rlock_take got=%b exp=01", rdy_a); end
    tick();
    v = 2'b00; eval_grants();
    total++; if (rv_a[0] !== 1'b1 || res_a0 !== 32'h0F00_0F00) begin bad++; $display("FAIL rlock_pending got=%b/%h exp=1/0f000f00", rv_a[0], res_a0); end
    reset = 1'b0; eval_grants(); tick();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      eval_grants();
      total++; if (rv_a !== 2'b00 || busy_a !== 1'b0 || rv_b !== 2'b00) begin bad++; $display("FAIL rlock_cleared cyc=%0d got=%b/%b/%b exp=00/0/00", c, rv_a, busy_a, rv_b); end
      tick();
    end
    rrdy = 2'b11;
    drive(0, 1'b1, ALU_OR, 32'd1, 32'd2, 1'b0);
    drive(1, 1'b1, ALU_OR, 32'd4, 32'd8, 1'b0);
    eval_grants();
    total++; if (rdy_a !== 2'b01 || rdy_b !== 2'b01) begin bad++; $display("FAIL rlock_tie got=%b/%b exp=01/01", rdy_a, rdy_b); end
    tick();
    v = 2'b00; eval_grants(); tick();
  endtask

  task automatic test_random();
    logic [1:0]  g_rv, g_z;
    logic [31:0] a;
    logic        eb;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) != 0);
      rrdy  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      for (int p = 0; p < 2; p++) begin
        a = $urandom();
        drive(p, ($urandom_range(0, 2) != 0), op_tab[$urandom_range(0, 13)], a,
              ($urandom_range(0, 3) == 0) ? a : $urandom(), ($urandom_range(0, 3) == 0));
      end
      eval_grants();
      for (int i = 0; i < 2; i++) begin
        g_rv = get_rv(i); g_z = get_z(i);
        total++; if (get_rdy(i) !== exp_rdy(i)) begin bad++; $display("FAIL rnd_ready inst=%0d cyc=%0d got=%b exp=%b", i, c, get_rdy(i), exp_rdy(i)); end
        eb = (m_owner[i] >= 0) || m_rv[i][0] || m_rv[i][1];
        total++; if (get_busy(i) !== eb) begin bad++; $display("FAIL rnd_busy inst=%0d cyc=%0d got=%b exp=%b", i, c, get_busy(i), eb); end
        for (int p = 0; p < 2; p++) begin
          total++; if (g_rv[p] !== m_rv[i][p]) begin bad++; $display("FAIL rnd_valid inst=%0d port=%0d cyc=%0d got=%b exp=%b", i, p, c, g_rv[p], m_rv[i][p]); end
          if (m_rv[i][p]) begin
            total++;
            if (get_res(i, p) !== m_res[i][p] || g_z[p] !== (m_res[i][p] == 32'd0)) begin
              bad++; $display("FAIL rnd_result inst=%0d port=%0d cyc=%0d got=%h/%b exp=%h", i, p, c, get_res(i, p), g_z[p], m_res[i][p]);
            end
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    op_tab = '{ALU_AND, ALU_OR, ALU_SUM, ALU_SUB, ALU_SLT, ALU_SRA, ALU_SLL,
               ALU_SRL, ALU_XOR, ALU_GE, ALU_NOR, ALU_GEU, ALU_EQ, ALU_SLTU};
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1; m_last[i] = 1; eg[i] = -1;
      for (int p = 0; p < 2; p++) begin m_rv[i][p] = 1'b0; m_res[i][p] = 32'd0; end
    end
    v = 2'b00; lk = 2'b00; rrdy = 2'b00; reset = 1'b0;
    for (int p = 0; p < 2; p++) begin op[p] = ALU_AND; x[p] = 32'd0; y[p] = 32'd0; end
    @(negedge clk);
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_lock();
    test_reset_in_lock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
